instr_loader: RTL
=================

# instr_loader

Front-end instruction entry stage that sits directly upstream of the processor core. It debounces the manual entry button and assembles pairs of 8-bit switch bytes into 16-bit instructions. It buffers these instructions in a small show-ahead FIFO and hands them to the core over a valid/ready handshake. It also drives a status word for the board LEDs.

## Interface
- `DEBOUNCE_CYCLES`, 16: number of consecutive enabled cycles the synchronized button must hold a new level before it is accepted (≥ 2).
- `DEPTH`, 8: FIFO entries; power of two, 2..32.
- `ADDR_W`, 3: log2(`DEPTH`).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `clk_enable`  in  1  cycle enable; gates all state except the synchronizer.
- `input_instruction`  in  8  switch byte.
- `button`  in  1  raw, asynchronous, bouncing entry button.
- `instr_ready`  in  1  core accepts the head instruction.
- `instr_out`  out  16  head-of-FIFO instruction (`mem[rd_ptr]`); 16'h0000 when empty.
- `instr_valid`  out  1  FIFO non-empty.
- `fifo_count`  out  `ADDR_W`+1  number of stored entries.
- `status_leds`  out  16  bit [15] = `phase`, bit [14] = `overflow`, bits [13:8] = `fifo_count` zero-extended, bits [7:0] = `hi_byte`.

## Operation
- **Synchronizer.**
  - Two flip-flops on `button`, clocked every `clk` and not gated by `clk_enable`.
  - The output is `btn_sync`.
- **Debouncer.**
  - Holds a registered `stable` level and a counter `db_cnt`.
  - On an enabled cycle where `btn_sync` ≠ `stable`, `db_cnt` increments.
  - When `db_cnt` = `DEBOUNCE_CYCLES`−1 on such a cycle, `stable` takes `btn_sync` and `db_cnt` clears.
  - On an enabled cycle where `btn_sync` = `stable`, `db_cnt` clears. Any bounce therefore restarts the count.
  - `press` = `stable` & ~`stable_d`, where `stable_d` is `stable` delayed one enabled cycle. `press` is high for exactly one enabled cycle per accepted press.
  - A release produces no event.
- **Assembler FSM.** Two states.
  - `HI` (reset state): on `press`, `hi_byte` ← `input_instruction` and the FSM moves to `LO`.
  - `LO`: on `press`, `push` is asserted with data {`hi_byte`, `input_instruction`} and the FSM returns to `HI`.
  - `phase` = 1 in `LO`.
  - `hi_byte` holds its value until the next capture.
- **FIFO.**
  - Read pointer, write pointer and count; pointers wrap modulo `DEPTH`.
  - `pop` = `instr_valid` & `instr_ready` & `clk_enable`.
  - A `push` is accepted if `fifo_count` < `DEPTH`, or if `pop` is active in the same cycle (full with simultaneous pop: both happen and the count is unchanged).
  - A rejected push discards the word, sets `overflow` sticky, and the FSM still returns to `HI`.
  - `overflow` clears only on reset.
  - Push and pop together on a non-full, non-empty FIFO leave the count unchanged and advance both pointers.
  - Push into an empty FIFO with `instr_ready` high: no pop that cycle, because `instr_valid` is still 0.
- **Reset** (async assert, any time, including mid-assembly or mid-debounce):
  - `phase` = `HI`, `hi_byte` = 0, `stable` = 0, `stable_d` = 0, `db_cnt` = 0.
  - Pointers = 0, `fifo_count` = 0, `overflow` = 0, synchronizer flip-flops = 0.
  - Outputs are therefore `instr_valid` = 0, `instr_out` = 0, `status_leds` = 0.
  - A partially assembled high byte is lost.
  - A button held through reset release is seen as a new press after debounce.
- With `clk_enable` low, no state changes except the synchronizer, and `pop` is suppressed.

## Timing
- Enabled edges needed from a clean `button` rise to `press` high: 2 `clk` edges of synchronizer + `DEBOUNCE_CYCLES` enabled edges.
- A `press` in `LO` writes the FIFO at the edge that ends the `press` cycle. `instr_valid` and `instr_out` update immediately after that edge (1-cycle latency).
- Pop takes effect at the enabled edge where `instr_valid` & `instr_ready`. The next entry (or empty) is presented after that edge.
- Outputs are registered or direct decodes of registers; there is no combinational path from any input to any output.

## Test plan
- **Reset / idle.** Reset low, then release; no button activity → `instr_valid` = 0, `fifo_count` = 0, `status_leds` = 16'h0000.
- **Debounce.** `clk_enable` = 1, `DEBOUNCE_CYCLES` = 16.
  - Button toggles every 5 cycles for 60 cycles, then held high → no press during bouncing.
  - Exactly one `press` occurs 18 cycles after the final rise.
  - Release, then a clean re-press → one additional event.
- **Assembly.** Switches 8'hA5, press; then 8'h3C, press.
  - `status_leds` [15] = 1 with [7:0] = A5 between the presses.
  - Afterwards `instr_out` = 16'hA53C, `instr_valid` = 1, `fifo_count` = 1.
  - Assert `instr_ready` for one cycle → `instr_valid` = 0.
- **Full / overflow.** `instr_ready` = 0.
  - Load 8 instructions 16'h0100..16'h0107, then a 9th 16'hFFFF → `fifo_count` = 8, `overflow` = 1.
  - Drain order is 0100..0107; FFFF never appears.
- **Simultaneous push / pop at full.** FIFO full; the second press of a pair coincides with `instr_ready` = 1 → count stays 8, the new word is appended and the head is removed.
- **Reset mid-operation.** Reset after the high byte is captured, with 3 entries queued → all flags and count 0. The next two presses form a fresh instruction.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader
// Front-end instruction entry stage for the processor core. It debounces the
// manual entry button and pairs two switch bytes into one 16-bit instruction.
// Finished instructions are queued in a small show-ahead FIFO, and the core
// takes them over a valid/ready handshake.
//
// Ports:
//   clk               system clock
//   reset             asynchronous, active-low reset
//   clk_enable        cycle enable (the button synchronizer ignores it)
//   input_instruction switch byte
//   button            raw, bouncing entry button
//   instr_ready       core accepts the head instruction this cycle
//   instr_out         head-of-FIFO instruction, 16'h0000 when empty
//   instr_valid       FIFO holds at least one instruction
//   fifo_count        number of stored instructions
//   status_leds       {phase, overflow, fifo_count (6 bits), hi_byte}
module instr_loader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = 8,
  parameter int ADDR_W          = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [7:0]        input_instruction,
  input  logic              button,
  input  logic              instr_ready,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  output logic [ADDR_W:0]   fifo_count,
  output logic [15:0]       status_leds
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);

  localparam logic [0:0] PH_HI = 1'b0;
  localparam logic [0:0] PH_LO = 1'b1;

  logic              btn_meta;
  logic              btn_sync;
  logic              stable;
  logic              stable_d;
  logic [DB_W-1:0]   db_cnt;
  logic              press;

  logic [0:0]        phase;
  logic [7:0]        hi_byte;
  logic              overflow;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              push;
  logic              pop;
  logic              accept;

  // This synchronizer brings the raw button into the clock domain. It runs on
  // every clock edge so that a disabled stretch does not leave a stale level
  // in the pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
    end
  end

  // The debouncer accepts a new level only after the synchronized button has
  // differed from the accepted level for DEBOUNCE_CYCLES consecutive enabled
  // cycles. Any return to the accepted level restarts the count. stable_d
  // lets us find the rising edge of the accepted level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
    end else if (clk_enable) begin
      stable_d <= stable;
      if (btn_sync != stable) begin
        if (db_cnt == DB_LAST) begin
          stable <= btn_sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // press stays high while clk_enable is low, because stable_d is frozen.
  // Consumers therefore qualify it with clk_enable.
  assign press  = stable & ~stable_d;

  assign pop    = instr_valid & instr_ready & clk_enable;
  assign push   = clk_enable & press & (phase == PH_LO);
  assign accept = push & ((fifo_count < DEPTH_CNT) | pop);

  // The assembler FSM alternates between capturing the high byte and
  // completing the word. The second press always returns it to HI, even when
  // a full FIFO discards the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase   <= PH_HI;
      hi_byte <= 8'h00;
    end else if (clk_enable && press) begin
      if (phase == PH_HI) begin
        hi_byte <= input_instruction;
        phase   <= PH_LO;
      end else begin
        phase   <= PH_HI;
      end
    end
  end

  // The overflow flag is sticky. It records any completed word that was lost
  // because the FIFO was full and no pop happened in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push && !accept) begin
      overflow <= 1'b1;
    end
  end

  // This block holds the FIFO pointers and the occupancy count. The pointers
  // wrap naturally because DEPTH is a power of two. A push and a pop in the
  // same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + (ADDR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (ADDR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The storage array has no reset. The output mux hides its contents
  // whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {hi_byte, input_instruction};
    end
  end

  assign instr_valid = (fifo_count != '0);
  assign instr_out   = instr_valid ? mem[rd_ptr] : 16'h0000;
  assign status_leds = {phase, overflow, 6'(fifo_count), hi_byte};

endmodule
